maxpool_seq_ctrl: RTL and testbench
===================================

Name: maxpool_seq_ctrl

Overview:
Sequencer that drives the 2x2/stride-2 max-pool reduction over a conv feature map held in a synchronous RAM, one window at a time. It replaces the flat-array pooling path with address-generated reads from the conv-output buffer and writes into the pooled-output buffer. A start/busy/done handshake lets the layer scheduler launch it once the conv stage has filled the input buffer.

Parameters:
IN_W, 28, input map width; must be even
IN_H, 28, input map height; must be even
DATA_W, 16, element width, unsigned
IN_AW, 10, input RAM address width; covers IN_W*IN_H-1
OUT_AW, 8, output RAM address width; covers (IN_W/2)*(IN_H/2)-1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  launch request, sampled only in IDLE
busy  out  1  high while a pass is in progress
done  out  1  one-cycle pulse at the end of a pass
rd_en  out  1  input RAM read enable
rd_addr  out  IN_AW  input RAM address, row-major (row*IN_W+col)
rd_data  in  DATA_W  input RAM data, valid exactly 1 cycle after rd_en
wr_en  out  1  output RAM write enable
wr_addr  out  OUT_AW  output RAM address, row-major (prow*IN_W/2+pcol)
wr_data  out  DATA_W  pooled maximum

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy, done, rd_en, wr_en=0; rd_addr, wr_addr, wr_data=0; window row/col counters, tap counter and accumulator=0. Reset mid-pass aborts immediately, with no further write. The next pass restarts at window 0.
- All outputs are registered, or decoded from registered state only. There is no combinational path from inputs to outputs.
- FSM states: IDLE, RD, DRAIN, WR, DONE.
- IDLE -> RD on a clock edge with start=1; busy goes to 1 on that edge.
- RD lasts 4 cycles, tap=0..3, with rd_en=1. Tap order for window (pr,pc):
  - tap 0: (2pr, 2pc)
  - tap 1: (2pr, 2pc+1)
  - tap 2: (2pr+1, 2pc)
  - tap 3: (2pr+1, 2pc+1)
- RD -> DRAIN after tap 3. DRAIN lasts 1 cycle, rd_en=0, and captures the tap-3 data.
- DRAIN -> WR. WR lasts 1 cycle: wr_en=1, wr_addr=pr*(IN_W/2)+pc, wr_data=accumulator.
- WR -> RD for the next window (pc increments; at pc=IN_W/2-1, pc wraps to 0 and pr increments).
- After the write for the last window (pr=IN_H/2-1, pc=IN_W/2-1), WR -> DONE.
- DONE lasts 1 cycle: done=1, busy=0. DONE -> IDLE.
- Accumulator:
  - The data returning for tap 0 loads the accumulator unconditionally; no stale value from the previous window may survive.
  - Taps 1-3 update it as acc = (rd_data > acc) ? rd_data : acc.
  - Comparison is unsigned, full DATA_W, with no saturation or truncation.
- Timing per window: 6 cycles. One pass is (IN_W/2)*(IN_H/2)*6 cycles from the start edge to the done edge; 1176 at defaults.
  - First rd_en cycle: immediately after the start edge.
  - First wr_en: cycle 6 after the start edge.
  - done: cycle 1177 after the start edge.
- start while busy, or in the DONE cycle, is ignored; it is neither queued nor restarting.
- start held high continuously gives back-to-back passes, with exactly one IDLE cycle between done and the next busy.
- wr_en and rd_en are never high in the same cycle.
- rd_addr and wr_addr stay within range at all times. Counters wrap to 0 at end of pass.
- wr_data holds its last value when wr_en=0.

Test Plan:
1. Ramp map, rd_data = addr[15:0], 28x28 -> 196 writes, window k writes (2pr+1)*28+2pc+1 (e.g. addr 0 gets 29, addr 195 gets 783); done at cycle 1177; exactly 196 wr_en pulses.
2. Max placed in each tap position in turn (7 at the target tap, 3 elsewhere), across windows 0-3 -> every write is 7. Separately: window 0 = 0xFFFF, window 1 = 0x0000 -> window 1 writes 0x0000 (proves reload on tap 0).
3. Unsigned check: taps 0x8000, 0x7FFF, 0x0001, 0x0000 -> 0x8000.
4. start pulsed at cycles 10 and 600 of a pass -> no effect; single done at 1177; wr_addr sequence 0..195 in order with no repeats.
5. rst low at cycle 300, released at 305, then start -> outputs 0 during reset, no wr_en after assertion; the new pass begins at window 0 and completes in 1176 cycles.
6. start held high for 2 passes -> done, 1 idle cycle, busy=1, second pass output identical to the first.

Source files
------------

// File: rtl/maxpool_seq_ctrl.sv
// maxpool_seq_ctrl: walks a conv feature map one 2x2 window at a time.
// For each window it reads four taps from the input RAM and keeps a running
// unsigned maximum. It then writes that maximum to the pooled-output RAM.
// Each window takes 6 cycles: 4 reads, 1 drain cycle for the last read, and 1 write.
module maxpool_seq_ctrl #(
  parameter int IN_W   = 28,
  parameter int IN_H   = 28,
  parameter int DATA_W = 16,
  parameter int IN_AW  = 10,
  parameter int OUT_AW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [IN_AW-1:0]  rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [OUT_AW-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam int OUT_W = IN_W / 2;
  localparam int OUT_H = IN_H / 2;
  localparam int PC_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int PR_W  = (OUT_H > 1) ? $clog2(OUT_H) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_DRAIN,
    S_WR,
    S_DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [1:0]        tap_reg;
  logic [PC_W-1:0]   pc_reg;
  logic [PR_W-1:0]   pr_reg;
  logic [DATA_W-1:0] acc_reg, acc_next;
  logic [DATA_W-1:0] wr_data_reg;
  logic              last_pc, last_pr;

  assign last_pc = (pc_reg == PC_W'(OUT_W - 1));
  assign last_pr = (pr_reg == PR_W'(OUT_H - 1));

  // State register; reset aborts any pass in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= S_IDLE;
    else      state_reg <= state_next;
  end

  // Next-state decode; start only matters in IDLE
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_RD;
      S_RD:    if (tap_reg == 2'd3) state_next = S_DRAIN;
      S_DRAIN: state_next = S_WR;
      S_WR:    state_next = (last_pc && last_pr) ? S_DONE : S_RD;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Tap and window counters; window counters wrap to 0 after the last write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tap_reg <= 2'd0;
      pc_reg  <= '0;
      pr_reg  <= '0;
    end else begin
      tap_reg <= (state_reg == S_RD) ? tap_reg + 2'd1 : 2'd0;
      if (state_reg == S_WR) begin
        if (last_pc) begin
          pc_reg <= '0;
          pr_reg <= last_pr ? '0 : pr_reg + PR_W'(1);
        end else begin
          pc_reg <= pc_reg + PC_W'(1);
        end
      end
    end
  end

  // Running max. Data for tap N arrives in the cycle after it is read,
  // so tap 0 data shows up during RD tap 1 and reloads the accumulator.
  // Taps 1..3 arrive during RD taps 2 and 3 and during DRAIN.
  always_comb begin
    acc_next = acc_reg;
    if (state_reg == S_RD && tap_reg == 2'd1)
      acc_next = rd_data;
    else if ((state_reg == S_RD && tap_reg != 2'd0) || state_reg == S_DRAIN)
      acc_next = (rd_data > acc_reg) ? rd_data : acc_reg;
  end

  // Accumulator and write-data registers. wr_data latches the final max on
  // entry to WR and holds it until the next window's write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_reg     <= '0;
      wr_data_reg <= '0;
    end else begin
      acc_reg <= acc_next;
      if (state_reg == S_DRAIN) wr_data_reg <= acc_next;
    end
  end

  // Output decode from registered state only
  always_comb begin
    busy    = (state_reg == S_RD) || (state_reg == S_DRAIN) || (state_reg == S_WR);
    done    = (state_reg == S_DONE);
    rd_en   = (state_reg == S_RD);
    wr_en   = (state_reg == S_WR);
    rd_addr = IN_AW'({pr_reg, tap_reg[1]}) * IN_AW'(IN_W) + IN_AW'({pc_reg, tap_reg[0]});
    wr_addr = OUT_AW'(pr_reg) * OUT_AW'(OUT_W) + OUT_AW'(pc_reg);
    wr_data = wr_data_reg;
  end

endmodule

// File: tb/tb_maxpool_seq_ctrl.sv
// Bench for maxpool_seq_ctrl. It models the input RAM, predicts every pooled
// write from the map contents, and checks pass timing and the start/reset handshakes.
module tb_maxpool_seq_ctrl;

  localparam int IN_W = 28;
  localparam int IN_H = 28;
  localparam int OW   = IN_W / 2;
  localparam int NW   = (IN_W / 2) * (IN_H / 2);
  localparam int NA   = IN_W * IN_H;

  logic        clk = 0;
  logic        rst = 0;
  logic        start = 0;
  logic        busy, done, rd_en, wr_en;
  logic [9:0]  rd_addr;
  logic [15:0] rd_data = 0;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;

  logic [15:0] mem [0:NA-1];
  logic [15:0] got [0:NW-1];
  int checks = 0;
  int failures = 0;
  int exp_idx = 0;
  int done_cnt = 0;
  int unsigned sig = 0;
  int unsigned last_sig = 0;

  maxpool_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  // Synchronous input RAM with one cycle of read latency
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic int tap_addr(input int k, input int t);
    return (2 * (k / OW) + t / 2) * IN_W + 2 * (k % OW) + t % 2;
  endfunction

  // Reference: the pooled value of window k is the max of its four map entries
  function automatic logic [15:0] win_max(input int k);
    logic [15:0] m;
    logic [15:0] v;
    m = 16'h0;
    for (int t = 0; t < 4; t++) begin
      v = mem[tap_addr(k, t)];
      if (v > m) m = v;
    end
    return m;
  endfunction

  // Per-cycle compare against the reference write sequence
  always @(negedge clk) begin
    if (!rst) begin
      exp_idx = 0;
      sig = 0;
    end else begin
      if (rd_en || wr_en) check("rd_wr_exclusive", {31'd0, rd_en & wr_en}, 32'd0);
      if (wr_en) begin
        if (exp_idx >= NW) begin
          check("extra_write", exp_idx, NW - 1);
        end else begin
          check("wr_addr", {24'd0, wr_addr}, exp_idx);
          check("wr_data", {16'd0, wr_data}, {16'd0, win_max(exp_idx)});
          got[exp_idx] = wr_data;
          sig = sig * 33 + wr_data;
        end
        exp_idx++;
      end
      if (done) begin
        check("writes_per_pass", exp_idx, NW);
        check("busy_in_done", {31'd0, busy}, 32'd0);
        done_cnt++;
        last_sig = sig;
        exp_idx = 0;
        sig = 0;
      end
    end
  end

  // Waits for done and counts cycles from the start edge. The start input can
  // be pulsed at chosen cycles or held high. The wait gives up at 'limit'.
  task automatic wait_done(input int n_start, input bit hold, input int p0, input int p1,
                           input int p2, input int limit, output int done_at, output int first_wr);
    int n;
    n = n_start;
    done_at = -1;
    first_wr = -1;
    while (done_at < 0 && n < limit) begin
      @(negedge clk);
      n++;
      start = hold || n == p0 || n == p1 || n == p2;
      if (n == 1) check("first_rd", {21'd0, rd_en, rd_addr}, {21'd0, 1'b1, 10'd0});
      if (wr_en && first_wr < 0) first_wr = n;
      if (done) done_at = n;
    end
  endtask

  task automatic run_pass(input bit hold, input int p0, input int p1, input int p2,
                          input int limit, output int done_at, output int first_wr);
    @(negedge clk);
    start = 1;
    @(posedge clk);
    wait_done(0, hold, p0, p1, p2, limit, done_at, first_wr);
  endtask

  task automatic check_pass_timing(input string tag, input int done_at, input int first_wr);
    check({tag, "_first_wr_cycle"}, first_wr, 6);
    check({tag, "_done_cycle"}, done_at, 1177);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctrl"}, {28'd0, busy, done, rd_en, wr_en}, 32'd0);
    check({tag, "_rd_addr"}, {22'd0, rd_addr}, 32'd0);
    check({tag, "_wr"}, {8'd0, wr_addr, wr_data}, 32'd0);
  endtask

  initial begin
    int d, f, dc;
    int unsigned s1;

    // Outputs held at zero during the initial reset
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1;
    @(negedge clk);

    // Ramp map: each window's max is its bottom-right tap
    for (int a = 0; a < NA; a++) mem[a] = 16'(a);
    run_pass(0, -1, -1, -1, 1400, d, f);
    check_pass_timing("ramp", d, f);
    @(negedge clk);
    check("ramp_win0", {16'd0, got[0]}, 32'd29);
    check("ramp_win195", {16'd0, got[NW-1]}, 32'd783);
    $display("pass ramp done_at=%0d first_wr=%0d", d, f);

    // Max in each tap position; then a reload test and an unsigned test
    for (int a = 0; a < NA; a++) mem[a] = 16'd3;
    for (int k = 0; k < 4; k++) mem[tap_addr(k, k)] = 16'd7;
    for (int t = 0; t < 4; t++) mem[tap_addr(4, t)] = 16'hFFFF;
    for (int t = 0; t < 4; t++) mem[tap_addr(5, t)] = 16'h0000;
    mem[tap_addr(6, 0)] = 16'h8000;
    mem[tap_addr(6, 1)] = 16'h7FFF;
    mem[tap_addr(6, 2)] = 16'h0001;
    mem[tap_addr(6, 3)] = 16'h0000;
    run_pass(0, -1, -1, -1, 1400, d, f);
    check_pass_timing("taps", d, f);
    @(negedge clk);
    for (int k = 0; k < 4; k++) check("tap_pos_max", {16'd0, got[k]}, 32'd7);
    check("all_ones_win", {16'd0, got[4]}, 32'h0000FFFF);
    check("reload_after_ones", {16'd0, got[5]}, 32'd0);
    check("unsigned_cmp", {16'd0, got[6]}, 32'h8000);
    check("filler_win", {16'd0, got[7]}, 32'd3);
    $display("pass taps w4=%0h w5=%0h w6=%0h", got[4], got[5], got[6]);

    // start during busy and during DONE is ignored
    for (int a = 0; a < NA; a++) mem[a] = 16'(a * 7 + 5);
    dc = done_cnt;
    run_pass(0, 10, 600, 1177, 1400, d, f);
    check_pass_timing("ignored_start", d, f);
    @(negedge clk);
    start = 0;
    repeat (3) begin
      @(negedge clk);
      check("no_restart_busy", {31'd0, busy}, 32'd0);
    end
    check("single_done", done_cnt - dc, 1);
    $display("pass ignored_start done_at=%0d", d);

    // Reset at cycle 300 aborts the pass; the next pass restarts at window 0
    run_pass(0, -1, -1, -1, 300, d, f);
    rst = 0;
    #1;
    check_outputs_zero("abort_reset");
    repeat (4) begin
      @(negedge clk);
      check_outputs_zero("abort_hold");
    end
    @(negedge clk);
    rst = 1;
    run_pass(0, -1, -1, -1, 1400, d, f);
    check_pass_timing("after_abort", d, f);
    $display("pass after_abort done_at=%0d", d);

    // start held high: two back-to-back passes with one IDLE cycle between them
    run_pass(1, -1, -1, -1, 1400, d, f);
    check_pass_timing("hold1", d, f);
    @(negedge clk);
    check("gap_idle", {30'd0, busy, done}, 32'd0);
    s1 = last_sig;
    @(negedge clk);
    check("gap_restart", {31'd0, busy}, 32'd1);
    wait_done(1, 1, -1, -1, -1, 1400, d, f);
    check("hold2_done_cycle", d, 1177);
    @(negedge clk);
    start = 0;
    check("hold2_same_output", last_sig, s1);
    $display("pass hold2 done_at=%0d sig=%0h", d, last_sig);

    if (d < 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=none required=1177");
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
